// File: rtl/bcd_timer.sv
// Three-digit BCD stopwatch/countdown core. A prescaler divides CLK into count
// ticks; the count runs up to 999 or down to 000 and pulses DONE on arrival.

module bcd_digit (
    input  logic [3:0] d,
    input  logic       up,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);
    always_comb begin
        q    = d;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (d >= 4'd9) begin
                    q    = 4'd0;
                    cout = 1'b1;
                end else begin
                    q = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    q    = 4'd9;
                    cout = 1'b1;
                end else begin
                    q = d - 4'd1;
                end
            end
        end
    end
endmodule

module bcd_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int PS_W     = 26
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        STOP,
    input  logic        CLEAR,
    input  logic        LOAD,
    input  logic [11:0] PRESET,
    input  logic        DIR,
    output logic [3:0]  units,
    output logic [3:0]  tens,
    output logic [3:0]  hundreds,
    output logic        RUNNING,
    output logic        DONE
);
    localparam int            NUM_DIG = 3;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);
    localparam logic [PS_W-1:0] PS_ONE = PS_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                        state_q, state_n;
    logic [PS_W-1:0]               ps_q, ps_n;
    logic [NUM_DIG-1:0][3:0]       cnt_q, cnt_n, cnt_step, preset_sat;
    logic [NUM_DIG:0]              carry;
    logic                          dir_q, dir_n;
    logic                          done_n;
    logic                          tick;
    logic                          step_term;
    logic                          start_term;

    // Ripple carry/borrow chain; the units digit always steps on a tick.
    assign carry[0] = 1'b1;

    generate
        for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
            bcd_digit u_dig (
                .d    (cnt_q[i]),
                .up   (~dir_q),
                .cin  (carry[i]),
                .q    (cnt_step[i]),
                .cout (carry[i+1])
            );
        end
    endgenerate

    always_comb begin
        preset_sat = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            preset_sat[i] = (PRESET[i*4 +: 4] > 4'd9) ? 4'd9 : PRESET[i*4 +: 4];
        end
    end

    assign tick       = (state_q == S_RUN) && (ps_q == PS_MAX);
    assign step_term  = dir_q ? (cnt_step == 12'h000) : (cnt_step == 12'h999);
    assign start_term = DIR   ? (cnt_q    == 12'h000) : (cnt_q    == 12'h999);

    // Commands resolve in priority order CLEAR > LOAD > STOP > START.
    always_comb begin
        state_n = state_q;
        ps_n    = ps_q;
        cnt_n   = cnt_q;
        dir_n   = dir_q;
        done_n  = 1'b0;
        if (CLEAR) begin
            cnt_n   = '0;
            ps_n    = '0;
            state_n = S_IDLE;
        end else if (LOAD && state_q != S_RUN) begin
            cnt_n   = preset_sat;
            ps_n    = '0;
            state_n = S_IDLE;
        end else if (STOP && state_q == S_RUN) begin
            state_n = S_PAUSE;
        end else if (START && state_q == S_IDLE) begin
            dir_n = DIR;
            if (start_term) begin
                state_n = S_DONE;
                done_n  = 1'b1;
            end else begin
                state_n = S_RUN;
                ps_n    = '0;
            end
        end else if (START && state_q == S_PAUSE) begin
            state_n = S_RUN;
        end else if (state_q == S_RUN) begin
            if (tick) begin
                ps_n = '0;
                // A carry out of the top digit would mean a wrap; never take it.
                if (!carry[NUM_DIG]) begin
                    cnt_n = cnt_step;
                end
                if (step_term) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end
            end else begin
                ps_n = ps_q + PS_ONE;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            ps_q    <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            RUNNING <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state_q <= state_n;
            ps_q    <= ps_n;
            cnt_q   <= cnt_n;
            dir_q   <= dir_n;
            RUNNING <= (state_n == S_RUN);
            DONE    <= done_n;
        end
    end

    assign units    = cnt_q[0];
    assign tens     = cnt_q[1];
    assign hundreds = cnt_q[2];

endmodule

// File: tb/tb_bcd_timer.sv
// Bench for bcd_timer: directed scenarios plus random command traffic, checked
// every cycle against an integer-arithmetic model of the stopwatch.

module tb_bcd_timer;
    localparam int TD = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0, STOP = 1'b0, CLEAR = 1'b0, LOAD = 1'b0, DIR = 1'b0;
    logic [11:0] PRESET = 12'h000;
    logic [3:0]  units, tens, hundreds;
    logic        RUNNING, DONE;

    int checks = 0;
    int errors = 0;

    int m_st, m_cnt, m_ps;
    bit m_dir, m_done, m_run;

    bcd_timer #(.TICK_DIV(TD), .PS_W(3)) dut (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .CLEAR(CLEAR),
        .LOAD(LOAD), .PRESET(PRESET), .DIR(DIR), .units(units), .tens(tens),
        .hundreds(hundreds), .RUNNING(RUNNING), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    function automatic logic [11:0] to_bcd(int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    function automatic int sat_digit(logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_cnt = 0; m_ps = 0; m_dir = 0; m_done = 0; m_run = 0;
    endtask

    // Stopwatch behaviour as decimal arithmetic on a 0..999 integer.
    task automatic model_step();
        bit tick;
        if (RST) begin
            model_reset();
            return;
        end
        tick   = (m_st == M_RUN) && (m_ps == TD - 1);
        m_done = 0;
        if (CLEAR) begin
            m_cnt = 0; m_ps = 0; m_st = M_IDLE;
        end else if (LOAD && m_st != M_RUN) begin
            m_cnt = sat_digit(PRESET[11:8]) * 100 + sat_digit(PRESET[7:4]) * 10
                  + sat_digit(PRESET[3:0]);
            m_ps = 0; m_st = M_IDLE;
        end else if (STOP && m_st == M_RUN) begin
            m_st = M_PAUSE;
        end else if (START && m_st == M_IDLE) begin
            m_dir = DIR;
            if ((DIR && m_cnt == 0) || (!DIR && m_cnt == 999)) begin
                m_st = M_DONE; m_done = 1;
            end else begin
                m_st = M_RUN; m_ps = 0;
            end
        end else if (START && m_st == M_PAUSE) begin
            m_st = M_RUN;
        end else if (m_st == M_RUN) begin
            if (tick) begin
                m_ps  = 0;
                m_cnt = m_dir ? m_cnt - 1 : m_cnt + 1;
                if ((m_dir && m_cnt == 0) || (!m_dir && m_cnt == 999)) begin
                    m_st = M_DONE; m_done = 1;
                end
            end else begin
                m_ps++;
            end
        end
        m_run = (m_st == M_RUN);
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        chk("count",   {hundreds, tens, units}, to_bcd(m_cnt));
        chk("running", {11'b0, RUNNING}, {11'b0, m_run});
        chk("done",    {11'b0, DONE},    {11'b0, m_done});
        START = 1'b0; STOP = 1'b0; CLEAR = 1'b0; LOAD = 1'b0;
    endtask

    function automatic logic [11:0] cnt_now();
        return {hundreds, tens, units};
    endfunction

    initial begin
        model_reset();
        repeat (2) cycle();
        chk("reset_count", cnt_now(), 12'h000);
        chk("reset_running", {11'b0, RUNNING}, 12'h000);
        RST = 1'b0;

        // Async reset mid-count at 057
        LOAD = 1'b1; PRESET = 12'h055; cycle();
        START = 1'b1; DIR = 1'b0; cycle();
        repeat (8) cycle();
        chk("pre_rst_057", cnt_now(), 12'h057);
        cycle();
        RST = 1'b1;
        #1;
        model_reset();
        chk("async_rst_count", cnt_now(), 12'h000);
        chk("async_rst_running", {11'b0, RUNNING}, 12'h000);
        #1 RST = 1'b0;
        START = 1'b1; DIR = 1'b0; cycle();
        repeat (4) cycle();
        chk("after_rst_001", cnt_now(), 12'h001);
        CLEAR = 1'b1; cycle();

        // Up count with carry into hundreds
        LOAD = 1'b1; PRESET = 12'h098; cycle();
        START = 1'b1; DIR = 1'b0; cycle();
        repeat (4) cycle();
        chk("up_099", cnt_now(), 12'h099);
        chk("up_running", {11'b0, RUNNING}, 12'h001);
        repeat (4) cycle();
        chk("up_100", cnt_now(), 12'h100);
        CLEAR = 1'b1; cycle();

        // Down to terminal
        LOAD = 1'b1; PRESET = 12'h002; cycle();
        START = 1'b1; DIR = 1'b1; cycle();
        repeat (4) cycle();
        chk("down_001", cnt_now(), 12'h001);
        repeat (4) cycle();
        chk("down_000", cnt_now(), 12'h000);
        chk("down_done_pulse", {11'b0, DONE}, 12'h001);
        cycle();
        chk("down_done_clear", {11'b0, DONE}, 12'h000);
        START = 1'b1; DIR = 1'b1; cycle();
        repeat (8) cycle();
        chk("down_frozen", cnt_now(), 12'h000);
        chk("down_not_running", {11'b0, RUNNING}, 12'h000);

        // Pause on the tick cycle, resume later
        LOAD = 1'b1; PRESET = 12'h010; cycle();
        START = 1'b1; DIR = 1'b0; cycle();
        repeat (3) cycle();
        STOP = 1'b1; cycle();
        chk("pause_count", cnt_now(), 12'h010);
        chk("pause_running", {11'b0, RUNNING}, 12'h000);
        repeat (10) cycle();
        START = 1'b1; cycle();
        chk("resume_hold", cnt_now(), 12'h010);
        cycle();
        chk("resume_tick", cnt_now(), 12'h011);

        // Priority and preset saturation
        CLEAR = 1'b1; LOAD = 1'b1; PRESET = 12'hA5F; cycle();
        chk("clear_over_load", cnt_now(), 12'h000);
        LOAD = 1'b1; PRESET = 12'hA5F; cycle();
        chk("load_sat", cnt_now(), 12'h959);
        START = 1'b1; DIR = 1'b0; cycle();
        LOAD = 1'b1; PRESET = 12'h123; cycle();
        chk("load_in_run", cnt_now(), 12'h959);
        CLEAR = 1'b1; cycle();

        // Already terminal at START
        LOAD = 1'b1; PRESET = 12'h999; cycle();
        START = 1'b1; DIR = 1'b0; cycle();
        chk("term_done", {11'b0, DONE}, 12'h001);
        chk("term_count", cnt_now(), 12'h999);
        chk("term_running", {11'b0, RUNNING}, 12'h000);
        cycle();
        chk("term_done_low", {11'b0, DONE}, 12'h000);
        chk("term_running_low", {11'b0, RUNNING}, 12'h000);

        // Random command traffic
        for (int n = 0; n < 1500; n++) begin
            START = ($urandom_range(0, 5) == 0);
            STOP  = ($urandom_range(0, 11) == 0);
            CLEAR = ($urandom_range(0, 59) == 0);
            LOAD  = ($urandom_range(0, 24) == 0);
            DIR   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0)
                PRESET = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                          4'($urandom_range(0, 9))};
            else
                PRESET = 12'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
